timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 162 ++++++++++++++++
 tb/tb_timer_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with one-shot and
// auto-reload periodic modes; irq feeds CP0 HWInt[0].
module timer_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  logic              irq_flag;

  logic       ctrl_en;
  logic [1:0] ctrl_mode;
  logic       ctrl_im;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       count_gt1;

  // FSM action strobes
  logic load_cnt;
  logic dec_cnt;
  logic expire;
  logic reload;
  logic clr_en;

  // Upper address bits are decoded by the bridge; collapse them here.
  logic unused_bits;
  assign unused_bits = ^{addr[29:2], din};

  assign ctrl_en   = ctrl[0];
  assign ctrl_mode = ctrl[2:1];
  assign ctrl_im   = ctrl[3];
  assign wr_ctrl   = we && (addr[1:0] == A_CTRL);
  assign wr_preset = we && (addr[1:0] == A_PRESET);
  assign count_gt1 = count > CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (ctrl_en) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_CNT;
      S_CNT: begin
        if (!ctrl_en) begin
          state_nxt = S_IDLE;
        end else if (!count_gt1) begin
          state_nxt = S_INT;
        end
      end
      S_INT: state_nxt = (ctrl_mode == MODE_PERIODIC) ? S_LOAD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM output strobes driving the datapath
  always_comb begin
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    expire   = 1'b0;
    reload   = 1'b0;
    clr_en   = 1'b0;
    unique case (state)
      S_LOAD: load_cnt = 1'b1;
      S_CNT: begin
        if (ctrl_en) begin
          dec_cnt = count_gt1;
          expire  = !count_gt1;
        end
      end
      S_INT: begin
        reload = (ctrl_mode == MODE_PERIODIC);
        clr_en = (ctrl_mode != MODE_PERIODIC);
      end
      default: ;
    endcase
  end

  // Registers: CPU writes win over the FSM clearing EN; the FSM setting
  // irq_flag wins over any clearing source.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= din[CTRL_W-1:0];
      end else if (clr_en) begin
        ctrl[0] <= 1'b0;
      end

      if (wr_preset) begin
        preset <= din[CNT_W-1:0];
      end

      if (load_cnt) begin
        count <= preset;
      end else if (dec_cnt) begin
        count <= count - CNT_W'(1);
      end else if (expire) begin
        count <= '0;
      end

      if (expire) begin
        irq_flag <= 1'b1;
      end else if (wr_ctrl || wr_preset || reload) begin
        irq_flag <= 1'b0;
      end
    end
  end

  // Read mux, combinational from addr
  always_comb begin
    dout = '0;
    unique case (addr[1:0])
      A_CTRL:   dout = DATA_W'(ctrl);
      A_PRESET: dout = DATA_W'(preset);
      A_COUNT:  dout = DATA_W'(count);
      default:  dout = '0;
    endcase
  end

  assign irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: cycle model plus directed checks.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_auto = 0;
  int f_auto = 0;
  int n_lit  = 0;
  int f_lit  = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the count is derived from the edge at which it was
  // loaded and the latched preset; expiry happens max(N,1) edges later.
  typedef enum {PH_IDLE, PH_ARM, PH_RUN, PH_FIRED} phase_t;
  phase_t      m_phase = PH_IDLE;
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count = '0;
  logic [31:0] m_n = '0;
  logic        m_flag = 1'b0;
  int          m_load_at = 0;
  int          t = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    bit     fire;
    longint elapsed;
    longint fire_after;
    fire = 1'b0;
    if (reset) begin
      m_ctrl   = '0;
      m_preset = '0;
      m_count  = '0;
      m_flag   = 1'b0;
      m_phase  = PH_IDLE;
      started  = 1'b1;
    end else begin
      case (m_phase)
        PH_IDLE: if (m_ctrl[0]) m_phase = PH_ARM;
        PH_ARM: begin
          m_n       = m_preset;
          m_load_at = t;
          m_count   = m_preset;
          m_phase   = PH_RUN;
        end
        PH_RUN: begin
          elapsed    = longint'(t - m_load_at);
          fire_after = (m_n == 0) ? 64'sd1 : longint'(m_n);
          if (!m_ctrl[0]) begin
            m_phase = PH_IDLE;
          end else if (elapsed >= fire_after) begin
            m_count = '0;
            m_flag  = 1'b1;
            fire    = 1'b1;
            m_phase = PH_FIRED;
          end else begin
            m_count = m_n - 32'(elapsed);
          end
        end
        default: begin
          if (m_ctrl[2:1] == 2'd1) begin
            m_flag  = 1'b0;
            m_phase = PH_ARM;
          end else begin
            m_ctrl[0] = 1'b0;
            m_phase   = PH_IDLE;
          end
        end
      endcase
      if (we && addr[1:0] == 2'd0) m_ctrl = din[3:0];
      if (we && addr[1:0] == 2'd1) m_preset = din;
      if (we && addr[1:0] <= 2'd1 && !fire) m_flag = 1'b0;
    end
    t = t + 1;
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin : compare
    logic [31:0] exp_dout;
    logic        exp_irq;
    if (started) begin
      case (addr[1:0])
        2'd0:    exp_dout = 32'(m_ctrl);
        2'd1:    exp_dout = m_preset;
        2'd2:    exp_dout = m_count;
        default: exp_dout = '0;
      endcase
      exp_irq = m_flag & m_ctrl[3];
      n_auto++;
      if (irq !== exp_irq) begin
        f_auto++;
        $display("FAIL model_irq t=%0d got %0b exp %0b", t, irq, exp_irq);
      end
      n_auto++;
      if (dout !== exp_dout) begin
        f_auto++;
        $display("FAIL model_dout t=%0d addr=%0d got 0x%0h exp 0x%0h",
                 t, addr[1:0], dout, exp_dout);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_lit++;
    if (got !== exp) begin
      f_lit++;
      $display("FAIL %s got 0x%0h exp 0x%0h", nm, got, exp);
    end
  endtask

  // One bus write; the write lands on the second rising edge after the call
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = {28'd0, a};
    din  = d;
    we   = 1'b1;
    @(posedge clk); #1;
    we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    addr = {28'd0, a};
    @(negedge clk);
    chk(nm, dout, exp);
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(2'd0, 32'h0, "rst_ctrl");
    chk("rst_irq", 32'(irq), 32'h0);
    rd(2'd1, 32'h0, "rst_preset");
    rd(2'd2, 32'h0, "rst_count");
    wr(2'd2, 32'h55);
    rd(2'd2, 32'h0, "count_ro");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h0, "addr3_zero");

    // Mode 0 one-shot, PRESET=5: irq after E7
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("m0_irq_e6", 32'(irq), 32'h0);
    @(negedge clk);
    chk("m0_irq_e7", 32'(irq), 32'h1);
    rd(2'd2, 32'h0, "m0_count");
    rd(2'd0, 32'h8, "m0_ctrl");
    chk("m0_irq_hold", 32'(irq), 32'h1);
    wr(2'd0, 32'h8);
    @(negedge clk);
    chk("m0_ack", 32'(irq), 32'h0);

    // Mode 1 periodic, PRESET=3: pulse every 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    addr = 30'd2;
    for (int k = 0; k <= 16; k++) begin
      logic e;
      @(negedge clk);
      e = (k >= 5) && (k % 5 == 0);
      chk("m1_irq", 32'(irq), 32'(e));
      if (k == 2 || k == 7 || k == 12) chk("m1_reload", dout, 32'd3);
    end
    wr(2'd0, 32'h0);

    // Masking: IM=0 keeps irq low, later unmask finds flag cleared
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mask_irq", 32'(irq), 32'h0);
    rd(2'd0, 32'h0, "mask_ctrl");
    wr(2'd0, 32'h8);
    @(negedge clk);
    chk("mask_unmask", 32'(irq), 32'h0);

    // Disable mid-count freezes COUNT; re-enable reloads from PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    repeat (3) @(posedge clk);
    wr(2'd0, 32'h0);
    rd(2'd2, 32'd7, "dis_freeze");
    repeat (4) @(posedge clk);
    rd(2'd2, 32'd7, "dis_hold");
    wr(2'd0, 32'h1);
    addr = 30'd2;
    @(negedge clk);
    @(negedge clk);
    chk("reen_pre", dout, 32'd7);
    @(negedge clk);
    chk("reen_load", dout, 32'd10);
    wr(2'd0, 32'h0);

    // PRESET=0 behaves like 1: irq after E3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("p0_irq_e2", 32'(irq), 32'h0);
    @(negedge clk);
    chk("p0_irq_e3", 32'(irq), 32'h1);
    wr(2'd0, 32'h8);
    @(negedge clk);
    chk("p0_ack", 32'(irq), 32'h0);

    // CPU CTRL write wins over FSM clearing EN in INT
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (2) @(posedge clk);
    wr(2'd0, 32'hD);
    rd(2'd0, 32'hD, "race_ctrl");
    chk("race_irq_clr", 32'(irq), 32'h0);
    repeat (3) @(negedge clk);
    chk("race_refire", 32'(irq), 32'h1);
    wr(2'd0, 32'h8);

    // FSM set of irq_flag wins over a same-cycle PRESET write
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    repeat (2) @(posedge clk);
    wr(2'd1, 32'd7);
    @(negedge clk);
    chk("set_wins", 32'(irq), 32'h1);
    rd(2'd1, 32'd7, "set_wins_preset");
    wr(2'd0, 32'h8);
    @(negedge clk);
    chk("set_wins_ack", 32'(irq), 32'h0);

    // Reset with irq pending
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    rd(2'd0, 32'h0, "mid_rst_ctrl");
    chk("mid_rst_irq", 32'(irq), 32'h0);
    rd(2'd1, 32'h0, "mid_rst_preset");
    rd(2'd2, 32'h0, "mid_rst_count");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_auto + n_lit, f_auto + f_lit);
    $finish;
  end

endmodule
